// File: rtl/irq_pkg.sv
// irq_pkg: register map addresses and access FSM state encoding shared by irq_ctrl
package irq_pkg;
  localparam logic [1:0] A_STS  = 2'd0;
  localparam logic [1:0] A_MASK = 2'd1;
  localparam logic [1:0] A_RAW  = 2'd2;
  localparam logic [1:0] A_CFG  = 2'd3;
  typedef enum logic [2:0] {S_IDLE, S_WR, S_RD_STS, S_RD_REG, S_RSP} state_t;
endpackage

// File: rtl/irq_ctrl_if.sv
// irq_ctrl_if: software register port (cs/wr/addr/wdata request, rdata/ack response)
interface irq_ctrl_if;
  logic        cs;
  logic        wr;
  logic [1:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ack;
  modport master (output cs, wr, addr, wdata, input rdata, ack);
  modport slave  (input cs, wr, addr, wdata, output rdata, ack);
endinterface

// File: rtl/irq_holdoff.sv
// irq_holdoff: turns a pending level into irq after a programmable hold-off (clk, rst_n, pend, holdoff -> irq)
module irq_holdoff #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         pend,
  input  logic [W-1:0] holdoff,
  output logic         irq
);
  logic         pend_q;
  logic [W-1:0] cnt, cnt_nxt;
  always_comb
    cnt_nxt = !pend ? '0 : !pend_q ? holdoff : (cnt == '0) ? '0 : cnt - 1'b1;
  // irq looks at the post-edge count so holdoff=N yields irq exactly N+1 cycles after pend rises
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pend_q <= 1'b0;
      cnt    <= '0;
      irq    <= 1'b0;
    end else begin
      pend_q <= pend;
      cnt    <= cnt_nxt;
      irq    <= pend && (cnt_nxt == '0);
    end
endmodule

// File: rtl/irq_ctrl.sv
// irq_ctrl: masks REG_RC sticky status into a coalesced irq and serves a small register port (clk, rst_n, sts->ren, bus, irq)
module irq_ctrl
  import irq_pkg::*;
#(
  parameter int              HOLD_W   = 16,
  parameter logic [HOLD_W-1:0] HOLD_INI = '0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] sts,
  output logic        ren,
  irq_ctrl_if.slave   bus,
  output logic        irq
);
  state_t            st;
  logic [1:0]        a_q;
  logic [31:0]       wd_q;
  logic [31:0]       mask;
  logic [HOLD_W-1:0] cfg;
  // ren is raised together with the capture edge of rdata so REG_RC clears exactly what was read
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st        <= S_IDLE;
      a_q       <= '0;
      wd_q      <= '0;
      mask      <= '0;
      cfg       <= HOLD_INI;
      ren       <= 1'b0;
      bus.ack   <= 1'b0;
      bus.rdata <= '0;
    end else begin
      ren     <= 1'b0;
      bus.ack <= 1'b0;
      case (st)
        S_IDLE:
          if (bus.cs) begin
            a_q     <= bus.addr;
            wd_q    <= bus.wdata;
            bus.ack <= bus.wr;
            ren     <= !bus.wr && (bus.addr == A_STS);
            st      <= bus.wr ? S_WR : (bus.addr == A_STS) ? S_RD_STS : S_RD_REG;
          end
        S_WR: begin
          if (a_q == A_MASK) mask <= wd_q;
          if (a_q == A_CFG) cfg <= wd_q[HOLD_W-1:0];
          st <= S_IDLE;
        end
        S_RD_STS: begin
          bus.rdata <= sts;
          bus.ack   <= 1'b1;
          st        <= S_RSP;
        end
        S_RD_REG: begin
          bus.rdata <= (a_q == A_MASK) ? mask : (a_q == A_RAW) ? sts : 32'(cfg);
          bus.ack   <= 1'b1;
          st        <= S_RSP;
        end
        default: st <= S_IDLE;
      endcase
    end
  irq_holdoff #(.W(HOLD_W)) u_holdoff (
    .clk    (clk),
    .rst_n  (rst_n),
    .pend   (|(sts & mask)),
    .holdoff(cfg),
    .irq    (irq)
  );
endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: directed checks of irq_ctrl against a REG_RC model and hand-computed expectations
module tb_irq_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] sts = '0;
  logic [31:0] din = '0;
  logic [31:0] load_val = '0;
  logic        load = 1'b0;
  logic        ren, irq;
  logic        r1, r2, a1, a2;
  logic [31:0] rd;
  int          n_cmp = 0;
  int          n_bad = 0;
  irq_ctrl_if bus();
  irq_ctrl dut (.clk(clk), .rst_n(rst_n), .sts(sts), .ren(ren), .bus(bus), .irq(irq));
  always #5 clk = ~clk;
  // REG_RC model: din wins over the clear strobe; load lets the bench preset the status
  always @(posedge clk) sts <= load ? load_val : ((ren ? 32'h0 : sts) | din);

  task automatic do_write(input logic [1:0] a, input logic [31:0] d, output logic ack1, output logic ack2);
    @(negedge clk); bus.cs = 1; bus.wr = 1; bus.addr = a; bus.wdata = d;
    @(negedge clk); bus.cs = 0; ack1 = bus.ack;
    @(negedge clk); ack2 = bus.ack;
  endtask

  task automatic do_read(input logic [1:0] a, output logic ren1, output logic ren2,
                         output logic ack1, output logic ack2, output logic [31:0] rdv);
    @(negedge clk); bus.cs = 1; bus.wr = 0; bus.addr = a;
    @(negedge clk); bus.cs = 0; ren1 = ren; ack1 = bus.ack;
    @(negedge clk); ren2 = ren; ack2 = bus.ack; rdv = bus.rdata;
  endtask

  task automatic set_sts(input logic [31:0] v);
    @(negedge clk); load = 1; load_val = v;
    @(negedge clk); load = 0;
  endtask

  task automatic test_reset;
    #12;
    n_cmp++; if (ren !== 1'b0) begin n_bad++; $display("FAIL reset_ren: got %b want 0", ren); end
    n_cmp++; if (bus.ack !== 1'b0) begin n_bad++; $display("FAIL reset_ack: got %b want 0", bus.ack); end
    n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL reset_irq: got %b want 0", irq); end
    n_cmp++; if (bus.rdata !== 32'h0) begin n_bad++; $display("FAIL reset_rdata: got %h want 0", bus.rdata); end
    @(negedge clk); rst_n = 1;
    do_read(2'd1, r1, r2, a1, a2, rd);
    n_cmp++; if (a2 !== 1'b1 || rd !== 32'h0) begin n_bad++; $display("FAIL reset_mask: ack %b rdata %h want 1 0", a2, rd); end
    do_read(2'd3, r1, r2, a1, a2, rd);
    n_cmp++; if (a2 !== 1'b1 || rd !== 32'h0) begin n_bad++; $display("FAIL reset_cfg: ack %b rdata %h want 1 0", a2, rd); end
    set_sts(32'h1);
    repeat (3) @(negedge clk);
    n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL masked_irq: got %b want 0", irq); end
  endtask

  task automatic test_mask_irq;
    do_write(2'd1, 32'h0000_00F0, a1, a2);
    n_cmp++; if (a1 !== 1'b1 || a2 !== 1'b0) begin n_bad++; $display("FAIL wr_ack: N+1 %b N+2 %b want 1 0", a1, a2); end
    set_sts(32'h10);
    n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL irq_h0_early: got %b want 0", irq); end
    @(negedge clk);
    n_cmp++; if (irq !== 1'b1) begin n_bad++; $display("FAIL irq_h0_rise: got %b want 1", irq); end
    do_write(2'd3, 32'h5, a1, a2);
    n_cmp++; if (a1 !== 1'b1) begin n_bad++; $display("FAIL cfg_wr_ack: got %b want 1", a1); end
    set_sts(32'h0);
    repeat (2) @(negedge clk);
    n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL irq_drop: got %b want 0", irq); end
    set_sts(32'h10);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      n_cmp++; if (irq !== (k == 6)) begin n_bad++; $display("FAIL irq_h5_c%0d: got %b want %b", k, irq, k == 6); end
    end
    do_write(2'd3, 32'h0, a1, a2);
  endtask

  task automatic test_sts_read;
    set_sts(32'hA5);
    @(negedge clk);
    n_cmp++; if (irq !== 1'b1) begin n_bad++; $display("FAIL sts_irq_pre: got %b want 1", irq); end
    do_read(2'd0, r1, r2, a1, a2, rd);
    n_cmp++; if (r1 !== 1'b1 || r2 !== 1'b0) begin n_bad++; $display("FAIL sts_ren: N+1 %b N+2 %b want 1 0", r1, r2); end
    n_cmp++; if (a1 !== 1'b0 || a2 !== 1'b1) begin n_bad++; $display("FAIL sts_ack: N+1 %b N+2 %b want 0 1", a1, a2); end
    n_cmp++; if (rd !== 32'hA5) begin n_bad++; $display("FAIL sts_rdata: got %h want a5", rd); end
    n_cmp++; if (irq !== 1'b1) begin n_bad++; $display("FAIL sts_irq_n2: got %b want 1", irq); end
    @(negedge clk);
    n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL sts_irq_n3: got %b want 0", irq); end
  endtask

  task automatic test_din_race;
    set_sts(32'hA5);
    @(negedge clk); bus.cs = 1; bus.wr = 0; bus.addr = 2'd0;
    @(negedge clk); bus.cs = 0; din = 32'h8;
    n_cmp++; if (ren !== 1'b1) begin n_bad++; $display("FAIL race_ren: got %b want 1", ren); end
    @(negedge clk); din = 32'h0;
    n_cmp++; if (bus.ack !== 1'b1 || bus.rdata !== 32'hA5) begin n_bad++; $display("FAIL race_rdata: ack %b rdata %h want 1 a5", bus.ack, bus.rdata); end
    n_cmp++; if (sts !== 32'h8) begin n_bad++; $display("FAIL race_keep: sts %h want 08", sts); end
    do_read(2'd0, r1, r2, a1, a2, rd);
    n_cmp++; if (a2 !== 1'b1 || rd !== 32'h8) begin n_bad++; $display("FAIL race_next: ack %b rdata %h want 1 08", a2, rd); end
  endtask

  task automatic test_raw;
    set_sts(32'h3);
    for (int k = 0; k < 2; k++) begin
      do_read(2'd2, r1, r2, a1, a2, rd);
      n_cmp++; if (r1 !== 1'b0 || r2 !== 1'b0 || a2 !== 1'b1 || rd !== 32'h3) begin
        n_bad++; $display("FAIL raw_%0d: ren %b%b ack %b rdata %h want 00 1 3", k, r1, r2, a2, rd);
      end
    end
    @(negedge clk); bus.cs = 1; bus.wr = 0; bus.addr = 2'd2;
    @(negedge clk); bus.cs = 0;
    @(negedge clk);
    n_cmp++; if (bus.ack !== 1'b1 || bus.rdata !== 32'h3) begin n_bad++; $display("FAIL raw_rsp: ack %b rdata %h want 1 3", bus.ack, bus.rdata); end
    bus.cs = 1; bus.addr = 2'd0;
    @(negedge clk); bus.cs = 0;
    n_cmp++; if (bus.ack !== 1'b0 || ren !== 1'b0) begin n_bad++; $display("FAIL rsp_cs_ign1: ack %b ren %b want 0 0", bus.ack, ren); end
    @(negedge clk);
    n_cmp++; if (bus.ack !== 1'b0 || ren !== 1'b0) begin n_bad++; $display("FAIL rsp_cs_ign2: ack %b ren %b want 0 0", bus.ack, ren); end
    n_cmp++; if (sts !== 32'h3) begin n_bad++; $display("FAIL raw_noclr: sts %h want 3", sts); end
  endtask

  task automatic test_reset_mid;
    do_write(2'd3, 32'h7, a1, a2);
    set_sts(32'hA5);
    @(negedge clk); bus.cs = 1; bus.wr = 0; bus.addr = 2'd0;
    @(negedge clk); bus.cs = 0;
    n_cmp++; if (ren !== 1'b1) begin n_bad++; $display("FAIL mid_ren_pre: got %b want 1", ren); end
    #1 rst_n = 0;
    #1;
    n_cmp++; if (ren !== 1'b0 || bus.ack !== 1'b0) begin n_bad++; $display("FAIL mid_async: ren %b ack %b want 0 0", ren, bus.ack); end
    n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL mid_irq: got %b want 0", irq); end
    @(negedge clk);
    n_cmp++; if (bus.ack !== 1'b0) begin n_bad++; $display("FAIL mid_noack: got %b want 0", bus.ack); end
    rst_n = 1;
    n_cmp++; if (sts !== 32'hA5) begin n_bad++; $display("FAIL mid_sts: got %h want a5", sts); end
    do_read(2'd1, r1, r2, a1, a2, rd);
    n_cmp++; if (a2 !== 1'b1 || rd !== 32'h0) begin n_bad++; $display("FAIL mid_mask: ack %b rdata %h want 1 0", a2, rd); end
    do_read(2'd3, r1, r2, a1, a2, rd);
    n_cmp++; if (a2 !== 1'b1 || rd !== 32'h0) begin n_bad++; $display("FAIL mid_cfg: ack %b rdata %h want 1 0", a2, rd); end
    n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL mid_irq_after: got %b want 0", irq); end
  endtask

  initial begin
    bus.cs = 0; bus.wr = 0; bus.addr = '0; bus.wdata = '0;
    test_reset;
    test_mask_irq;
    test_sts_read;
    test_din_race;
    test_raw;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
